// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
//   Dynamic branch predictor for the MIPS32 pipeline. A table of ENTRIES
//   saturating counters (CNT_W bits each) is indexed by the fetch PC. With
//   HIST_W > 0 the index is the PC bits XORed with a global history register
//   (gshare). With HIST_W = 0 the index is the PC bits only (bimodal).
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     hazard_stall            pipeline stall; suppresses training and redirects
//     pred_pc                 IF-stage PC
//     pred_taken, pred_idx    prediction and the table index it came from
//     branch_write_enable     a conditional branch resolves this cycle
//     jump_write_enable       an unconditional jump resolves this cycle
//     upd_idx, upd_pred_taken index and prediction carried from fetch
//     branch_taken            actual branch outcome
//     write_target            resolved taken target
//     write_address           PC of the resolving instruction
//     valid                   a resolve is being processed this cycle
//     mispred_sel             redirect the PC mux to mispred_correct_target
//     mispred_correct_target  redirect address (0 when no redirect)
//     mispred_count           saturating count of redirects
//
//   Handshake: there is no back-pressure. A resolve is accepted in any cycle
//   where an enable is high and hazard_stall is low; valid reports exactly
//   that, and the table, history and counter update at the following edge.
// ---------------------------------------------------------------------------
module branch_history_table #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 0,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             branch_write_enable,
  input  logic             jump_write_enable,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_pred_taken,
  input  logic             branch_taken,
  input  logic [31:0]      write_target,
  input  logic [31:0]      write_address,
  output logic             valid,
  output logic             mispred_sel,
  output logic [31:0]      mispred_correct_target,
  output logic [31:0]      mispred_count
);

  // Weakly not taken: MSB clear, every lower bit set.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] cnt_table [ENTRIES];
  logic [IDX_W-1:0] hist_ext;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [31:0]      raw_target;
  logic [31:0]      mispred_count_q;
  logic             unused_pc_bits;

  // Only the word-index bits of the PC take part in the lookup.
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  // ---------------------------------------------------------------------
  // Global history (only present in the gshare configuration)
  // ---------------------------------------------------------------------
  if (HIST_W > 0) begin : g_gshare
    logic [HIST_W-1:0] ghr;

    // Jumps carry no direction information, so only branches shift in.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ghr <= '0;
      end else if (valid && !jump_write_enable) begin
        ghr <= (ghr << 1) | HIST_W'(branch_taken);
      end
    end

    assign hist_ext = IDX_W'(ghr);
  end else begin : g_bimodal
    assign hist_ext = '0;
  end

  // ---------------------------------------------------------------------
  // Prediction. The read is the pre-edge value even if the same entry is
  // being trained this cycle.
  // ---------------------------------------------------------------------
  assign pred_idx   = pred_pc[IDX_W+1:2] ^ hist_ext;
  assign pred_taken = cnt_table[pred_idx][CNT_W-1];

  // ---------------------------------------------------------------------
  // Resolve. Misprediction is judged against the prediction carried from
  // fetch, so training that happened in between cannot hide a redirect.
  // ---------------------------------------------------------------------
  always_comb begin
    cur_cnt                = cnt_table[upd_idx];
    nxt_cnt                = cur_cnt;
    valid                  = 1'b0;
    mispred_sel            = 1'b0;
    raw_target             = '0;
    mispred_correct_target = '0;
    if (!hazard_stall) begin
      if (jump_write_enable) begin
        valid       = 1'b1;
        mispred_sel = !upd_pred_taken;
        raw_target  = write_target;
        nxt_cnt     = '1;
      end else if (branch_write_enable) begin
        valid       = 1'b1;
        mispred_sel = (branch_taken != upd_pred_taken);
        raw_target  = branch_taken ? write_target : (write_address + 32'd4);
        if (branch_taken) begin
          if (cur_cnt != '1) nxt_cnt = cur_cnt + 1'b1;
        end else begin
          if (cur_cnt != '0) nxt_cnt = cur_cnt - 1'b1;
        end
      end
    end
    if (mispred_sel) mispred_correct_target = raw_target;
  end

  // ---------------------------------------------------------------------
  // Counter table, single write port.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_table[i] <= CNT_INIT;
    end else if (valid) begin
      cnt_table[upd_idx] <= nxt_cnt;
    end
  end

  // ---------------------------------------------------------------------
  // Misprediction counter, saturating at all-ones.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_count_q <= '0;
    end else if (mispred_sel && (mispred_count_q != 32'hFFFF_FFFF)) begin
      mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // -------------------------------------------------------------------
  // Shared stimulus, separate outputs for the two configurations
  // -------------------------------------------------------------------
  logic             hazard_stall;
  logic [31:0]      pred_pc;
  logic             branch_write_enable;
  logic             jump_write_enable;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_pred_taken;
  logic             branch_taken;
  logic [31:0]      write_target;
  logic [31:0]      write_address;

  logic             pred_taken,  pred_taken_h;
  logic [IDX_W-1:0] pred_idx,    pred_idx_h;
  logic             valid,       valid_h;
  logic             mispred_sel, mispred_sel_h;
  logic [31:0]      target,      target_h;
  logic [31:0]      mcount,      mcount_h;

  branch_history_table #(.ENTRIES(ENTRIES), .CNT_W(2), .HIST_W(0)) dut (
    .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_idx(pred_idx),
    .branch_write_enable(branch_write_enable), .jump_write_enable(jump_write_enable),
    .upd_idx(upd_idx), .upd_pred_taken(upd_pred_taken), .branch_taken(branch_taken),
    .write_target(write_target), .write_address(write_address),
    .valid(valid), .mispred_sel(mispred_sel),
    .mispred_correct_target(target), .mispred_count(mcount)
  );

  branch_history_table #(.ENTRIES(ENTRIES), .CNT_W(2), .HIST_W(2)) dut_h (
    .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .pred_pc(pred_pc),
    .pred_taken(pred_taken_h), .pred_idx(pred_idx_h),
    .branch_write_enable(branch_write_enable), .jump_write_enable(jump_write_enable),
    .upd_idx(upd_idx), .upd_pred_taken(upd_pred_taken), .branch_taken(branch_taken),
    .write_target(write_target), .write_address(write_address),
    .valid(valid_h), .mispred_sel(mispred_sel_h),
    .mispred_correct_target(target_h), .mispred_count(mcount_h)
  );

  int checks_total;
  int checks_passed;

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic drive_idle();
    hazard_stall        = 1'b0;
    branch_write_enable = 1'b0;
    jump_write_enable   = 1'b0;
    upd_idx             = '0;
    upd_pred_taken      = 1'b0;
    branch_taken        = 1'b0;
    write_target        = '0;
    write_address       = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------
  // Test 1: reset state, then training idx 16 to strongly taken.
  // Fetch runs one cycle ahead of resolve, so the prediction carried into
  // each resolve is the one read a cycle earlier.
  // -------------------------------------------------------------------
  task automatic test_reset_and_train();
    logic       fetched;
    logic [3:0] exp_sel;
    apply_reset();
    pred_pc = 32'h0000_0040;
    #1;
    checks_total++;
    if (pred_idx !== 6'd16) $display("FAIL reset_idx: got %0d want 16", pred_idx);
    else checks_passed++;
    checks_total++;
    if (pred_taken !== 1'b0) $display("FAIL reset_taken: got %b want 0", pred_taken);
    else checks_passed++;
    checks_total++;
    if (mcount !== 32'd0) $display("FAIL reset_count: got %h want 0", mcount);
    else checks_passed++;
    fetched = pred_taken;
    exp_sel = 4'b0011;  // element i is resolve number i: 1,1,0,0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      branch_write_enable = 1'b1;
      branch_taken        = 1'b1;
      upd_idx             = 6'd16;
      upd_pred_taken      = fetched;
      #1;
      fetched = pred_taken;
      checks_total++;
      if (mispred_sel !== exp_sel[i])
        $display("FAIL train_sel[%0d]: got %b want %b", i, mispred_sel, exp_sel[i]);
      else checks_passed++;
      @(posedge clk);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (dut.cnt_table[16] !== 2'd3) $display("FAIL train_cnt: got %0d want 3", dut.cnt_table[16]);
    else checks_passed++;
    checks_total++;
    if (mcount !== 32'd2) $display("FAIL train_count: got %0d want 2", mcount);
    else checks_passed++;
  endtask

  // -------------------------------------------------------------------
  // Test 2: strongly taken counter resolves not taken
  // -------------------------------------------------------------------
  task automatic test_branch_not_taken();
    @(negedge clk);
    branch_write_enable = 1'b1;
    branch_taken        = 1'b0;
    upd_idx             = 6'd16;
    upd_pred_taken      = 1'b1;
    write_address       = 32'h0000_0100;
    write_target        = 32'h0000_0800;
    #1;
    checks_total++;
    if (mispred_sel !== 1'b1) $display("FAIL nt_sel: got %b want 1", mispred_sel);
    else checks_passed++;
    checks_total++;
    if (target !== 32'h0000_0104) $display("FAIL nt_target: got %h want 00000104", target);
    else checks_passed++;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (dut.cnt_table[16] !== 2'd2) $display("FAIL nt_cnt: got %0d want 2", dut.cnt_table[16]);
    else checks_passed++;
    checks_total++;
    if (mcount !== 32'd3) $display("FAIL nt_count: got %0d want 3", mcount);
    else checks_passed++;
  endtask

  // -------------------------------------------------------------------
  // Test 3: jumps, including both enables together
  // -------------------------------------------------------------------
  task automatic test_jump();
    @(negedge clk);
    jump_write_enable = 1'b1;
    upd_idx           = 6'd16;
    upd_pred_taken    = 1'b0;
    write_target      = 32'h0040_0000;
    #1;
    checks_total++;
    if (mispred_sel !== 1'b1 || target !== 32'h0040_0000)
      $display("FAIL jump_mis: got sel=%b tgt=%h want sel=1 tgt=00400000", mispred_sel, target);
    else checks_passed++;
    @(posedge clk);
    @(negedge clk);
    upd_pred_taken = 1'b1;
    #1;
    checks_total++;
    if (dut.cnt_table[16] !== 2'd3) $display("FAIL jump_cnt: got %0d want 3", dut.cnt_table[16]);
    else checks_passed++;
    checks_total++;
    if (valid !== 1'b1 || mispred_sel !== 1'b0 || target !== 32'd0)
      $display("FAIL jump_hit: got v=%b sel=%b tgt=%h want v=1 sel=0 tgt=0", valid, mispred_sel, target);
    else checks_passed++;
    @(posedge clk);
    // Both enables, not-taken branch outcome: must behave as a jump only.
    @(negedge clk);
    branch_write_enable = 1'b1;
    branch_taken        = 1'b0;
    upd_pred_taken      = 1'b0;
    write_address       = 32'h0000_0200;
    #1;
    checks_total++;
    if (mispred_sel !== 1'b1 || target !== 32'h0040_0000)
      $display("FAIL both_en: got sel=%b tgt=%h want sel=1 tgt=00400000", mispred_sel, target);
    else checks_passed++;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (dut.cnt_table[16] !== 2'd3) $display("FAIL both_cnt: got %0d want 3", dut.cnt_table[16]);
    else checks_passed++;
    checks_total++;
    if (mcount !== 32'd5) $display("FAIL jump_count: got %0d want 5", mcount);
    else checks_passed++;
  endtask

  // -------------------------------------------------------------------
  // Test 4: stall blocks everything; then not-taken target wraps
  // -------------------------------------------------------------------
  task automatic test_stall_and_wrap();
    @(negedge clk);
    hazard_stall        = 1'b1;
    branch_write_enable = 1'b1;
    branch_taken        = 1'b0;
    upd_idx             = 6'd16;
    upd_pred_taken      = 1'b1;
    write_address       = 32'h0000_0100;
    #1;
    checks_total++;
    if (valid !== 1'b0 || mispred_sel !== 1'b0 || target !== 32'd0)
      $display("FAIL stall_out: got v=%b sel=%b tgt=%h want 0/0/0", valid, mispred_sel, target);
    else checks_passed++;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (dut.cnt_table[16] !== 2'd3 || mcount !== 32'd5)
      $display("FAIL stall_state: got cnt=%0d count=%0d want 3/5", dut.cnt_table[16], mcount);
    else checks_passed++;
    branch_write_enable = 1'b1;
    branch_taken        = 1'b0;
    upd_idx             = 6'd5;
    upd_pred_taken      = 1'b1;
    write_address       = 32'hFFFF_FFFE;
    #1;
    checks_total++;
    if (target !== 32'h0000_0002) $display("FAIL wrap_target: got %h want 00000002", target);
    else checks_passed++;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (dut.cnt_table[5] !== 2'd0 || dut.cnt_table[16] !== 2'd3)
      $display("FAIL wrap_cnt: got c5=%0d c16=%0d want 0/3", dut.cnt_table[5], dut.cnt_table[16]);
    else checks_passed++;
  endtask

  // -------------------------------------------------------------------
  // Test 5: gshare index follows branch history, jumps do not shift it
  // -------------------------------------------------------------------
  task automatic test_gshare();
    apply_reset();
    pred_pc = 32'h0000_0040;
    #1;
    checks_total++;
    if (pred_idx_h !== 6'd16) $display("FAIL gs_reset_idx: got %0d want 16", pred_idx_h);
    else checks_passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      branch_write_enable = 1'b1;
      branch_taken        = 1'b1;
      upd_idx             = 6'd0;
      upd_pred_taken      = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (pred_idx_h !== 6'd19) $display("FAIL gs_idx: got %0d want 19", pred_idx_h);
    else checks_passed++;
    checks_total++;
    if (pred_idx !== 6'd16) $display("FAIL bimodal_idx: got %0d want 16", pred_idx);
    else checks_passed++;
    jump_write_enable = 1'b1;
    upd_idx           = 6'd1;
    upd_pred_taken    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (pred_idx_h !== 6'd19) $display("FAIL gs_jump_idx: got %0d want 19", pred_idx_h);
    else checks_passed++;
    // One not-taken branch: history 2'b11 -> 2'b10, index 16^2 = 18.
    branch_write_enable = 1'b1;
    branch_taken        = 1'b0;
    upd_idx             = 6'd0;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    checks_total++;
    if (pred_idx_h !== 6'd18) $display("FAIL gs_shift_idx: got %0d want 18", pred_idx_h);
    else checks_passed++;
  endtask

  // -------------------------------------------------------------------
  // Test 6: counter saturation and asynchronous reset
  // -------------------------------------------------------------------
  task automatic test_count_saturate();
    @(negedge clk);
    force dut.mispred_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_count_q;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      branch_write_enable = 1'b1;
      branch_taken        = 1'b1;
      upd_idx             = 6'd7;
      upd_pred_taken      = 1'b0;
      @(posedge clk);
      #1;
      checks_total++;
      if (mcount !== 32'hFFFF_FFFF) $display("FAIL sat_count[%0d]: got %h want ffffffff", i, mcount);
      else checks_passed++;
    end
    @(negedge clk);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (mcount !== 32'd0) $display("FAIL async_rst_count: got %h want 0", mcount);
    else checks_passed++;
    checks_total++;
    if (dut.cnt_table[7] !== 2'd1) $display("FAIL async_rst_cnt: got %0d want 1", dut.cnt_table[7]);
    else checks_passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------
  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n         = 1'b0;
    pred_pc       = '0;
    drive_idle();
    test_reset_and_train();
    test_branch_not_taken();
    test_jump();
    test_stall_and_wrap();
    test_gshare();
    test_count_saturate();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
